// File: rtl/layer_pkg.sv
// Shared types and constants for the layer compositor: colour key, attribute record
// and the pixel pipeline depth.
package layer_pkg;

    localparam int          LAYER_PHY_W  = 16;
    localparam int          LAYER_SCR_W  = 10;
    localparam logic [11:0] COLOR_KEY    = 12'hF0F;
    localparam int          PIPE_LATENCY = 3;

    typedef struct packed {
        logic                   en;
        logic [LAYER_PHY_W-1:0] x;
        logic [LAYER_PHY_W-1:0] y;
        logic [LAYER_SCR_W-1:0] w;
        logic [LAYER_SCR_W-1:0] h;
    } layer_attr_t;

endpackage

// File: rtl/layer_priority_mux.sv
// Picks the lowest-index visible layer's pixel, else the background pixel.
// With LAYER_COLORKEY_EN defined, a layer pixel equal to COLOR_KEY is treated as transparent.
module layer_priority_mux
    import layer_pkg::*;
#(
    parameter int LAYER_NUM   = 8,
    parameter int PIXEL_WIDTH = 12
) (
    input  logic [LAYER_NUM-1:0]             layer_on_i,
    input  logic [LAYER_NUM*PIXEL_WIDTH-1:0] layer_rgb_i,
    input  logic [PIXEL_WIDTH-1:0]           bg_rgb_i,
    output logic [PIXEL_WIDTH-1:0]           pix_o
);

    logic [LAYER_NUM-1:0] key_hit;

`ifdef LAYER_COLORKEY_EN
    always_comb begin
        key_hit = '0;
        for (int i = 0; i < LAYER_NUM; i++) begin
            key_hit[i] = (layer_rgb_i[i*PIXEL_WIDTH +: PIXEL_WIDTH] == PIXEL_WIDTH'(COLOR_KEY));
        end
    end
`else
    assign key_hit = '0;
`endif

    // Walk from lowest priority upward so the lowest index overwrites last.
    always_comb begin
        pix_o = bg_rgb_i;
        for (int i = LAYER_NUM - 1; i >= 0; i--) begin
            if (layer_on_i[i] && !key_hit[i]) begin
                pix_o = layer_rgb_i[i*PIXEL_WIDTH +: PIXEL_WIDTH];
            end
        end
    end

endmodule

// File: rtl/layer_compositor.sv
// Rectangular-layer compositor: double-banked layer attributes swapped at frame start,
// three-stage lookup / priority / output pipeline. Optional colour key: LAYER_COLORKEY_EN.
module layer_compositor
    import layer_pkg::*;
#(
    parameter int LAYER_NUM    = 8,
    parameter int PIXEL_WIDTH  = 12,
    parameter int SCREEN_WIDTH = 10,
    parameter int PHY_WIDTH    = 16,
    parameter int CAMERA_WIDTH = 6,
    parameter int BLOCK_WIDTH  = 480
) (
    input  logic                              sys_clk,
    input  logic                              sys_rst,
    input  logic                              video_on,
    input  logic [SCREEN_WIDTH-1:0]           x,
    input  logic [SCREEN_WIDTH-1:0]           y,
    input  logic                              frame_start,
    input  logic [CAMERA_WIDTH-1:0]           camera_y,
    input  logic                              cfg_valid,
    input  logic [$clog2(LAYER_NUM)-1:0]      cfg_layer,
    input  logic [PHY_WIDTH-1:0]              cfg_x,
    input  logic [PHY_WIDTH-1:0]              cfg_y,
    input  logic [SCREEN_WIDTH-1:0]           cfg_w,
    input  logic [SCREEN_WIDTH-1:0]           cfg_h,
    input  logic                              cfg_en,
    output logic                              cfg_ready,
    input  logic                              cfg_commit,
    output logic [LAYER_NUM-1:0]              layer_on,
    output logic [LAYER_NUM*SCREEN_WIDTH-1:0] layer_x_rom,
    output logic [LAYER_NUM*SCREEN_WIDTH-1:0] layer_y_rom,
    input  logic [LAYER_NUM*PIXEL_WIDTH-1:0]  layer_rgb,
    input  logic [PIXEL_WIDTH-1:0]            bg_rgb,
    output logic [PIXEL_WIDTH-1:0]            rgb,
    output logic                              video_on_d,
    output logic                              commit_busy
);

    localparam int CW = PHY_WIDTH + 1;

    layer_attr_t                     pend_q [LAYER_NUM];
    layer_attr_t                     act_q  [LAYER_NUM];
    layer_attr_t                     cfg_attr;
    logic                            busy_q, busy_d;
    logic [CAMERA_WIDTH-1:0]         cam_q;
    logic                            swap, wr_en;

    logic [CW-1:0]                   cam_off, xp, yp;
    logic [LAYER_NUM-1:0]            on_d, on_q;
    logic [LAYER_NUM*SCREEN_WIDTH-1:0] xr_d, xr_q, yr_d, yr_q;
    logic [PIPE_LATENCY-1:0]         vld_q;
    logic [PIXEL_WIDTH-1:0]          pix_d, pix_q, rgb_q;

    // A write on the swap cycle would race the bank copy, so it is held off one cycle.
    assign swap      = frame_start && busy_q;
    assign cfg_ready = !swap;
    assign wr_en     = cfg_valid && cfg_ready;

    assign cfg_attr = '{en: cfg_en,
                        x:  LAYER_PHY_W'(cfg_x),
                        y:  LAYER_PHY_W'(cfg_y),
                        w:  LAYER_SCR_W'(cfg_w),
                        h:  LAYER_SCR_W'(cfg_h)};

    always_comb begin
        busy_d = busy_q;
        if (swap) begin
            busy_d = 1'b0;
        end
        if (cfg_commit) begin
            busy_d = 1'b1;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            for (int i = 0; i < LAYER_NUM; i++) begin
                pend_q[i] <= '0;
                act_q[i]  <= '0;
            end
            busy_q <= 1'b0;
            cam_q  <= '0;
        end else begin
            if (wr_en) begin
                pend_q[cfg_layer] <= cfg_attr;
            end
            if (swap) begin
                act_q <= pend_q;
                cam_q <= camera_y;
            end
            busy_q <= busy_d;
        end
    end

    assign cam_off = CW'(cam_q) * CW'(BLOCK_WIDTH);
    assign xp      = CW'(x);
    assign yp      = CW'(y) + cam_off;

    // One bit wider than the attribute fields so ax+w and ay+h cannot wrap.
    always_comb begin
        on_d = '0;
        xr_d = '0;
        yr_d = '0;
        for (int i = 0; i < LAYER_NUM; i++) begin
            if (act_q[i].en &&
                (xp >= CW'(act_q[i].x)) && (xp < CW'(act_q[i].x) + CW'(act_q[i].w)) &&
                (yp >= CW'(act_q[i].y)) && (yp < CW'(act_q[i].y) + CW'(act_q[i].h))) begin
                on_d[i] = 1'b1;
                xr_d[i*SCREEN_WIDTH +: SCREEN_WIDTH] = SCREEN_WIDTH'(xp - CW'(act_q[i].x));
                yr_d[i*SCREEN_WIDTH +: SCREEN_WIDTH] = SCREEN_WIDTH'(yp - CW'(act_q[i].y));
            end
        end
    end

    layer_priority_mux #(
        .LAYER_NUM   (LAYER_NUM),
        .PIXEL_WIDTH (PIXEL_WIDTH)
    ) u_prio (
        .layer_on_i  (on_q),
        .layer_rgb_i (layer_rgb),
        .bg_rgb_i    (bg_rgb),
        .pix_o       (pix_d)
    );

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            on_q  <= '0;
            xr_q  <= '0;
            yr_q  <= '0;
            vld_q <= '0;
            pix_q <= '0;
            rgb_q <= '0;
        end else begin
            on_q  <= on_d;
            xr_q  <= xr_d;
            yr_q  <= yr_d;
            vld_q <= {vld_q[PIPE_LATENCY-2:0], video_on};
            pix_q <= pix_d;
            rgb_q <= vld_q[PIPE_LATENCY-2] ? pix_q : '0;
        end
    end

    assign layer_on    = on_q;
    assign layer_x_rom = xr_q;
    assign layer_y_rom = yr_q;
    assign rgb         = rgb_q;
    assign video_on_d  = vld_q[PIPE_LATENCY-1];
    assign commit_busy = busy_q;

endmodule

// File: tb/tb_layer_compositor.sv
// Directed bench for layer_compositor: vector table per configuration phase plus
// hand-written sequences for commit timing, cfg back-pressure and mid-line reset.
module tb_layer_compositor;

    localparam int LN   = 8;
    localparam int PW   = 12;
    localparam int SW   = 10;
    localparam int PHW  = 16;
    localparam int CAMW = 6;
    localparam logic [PW-1:0] BG = 12'h0C3;

    logic                 sys_clk = 1'b0;
    logic                 sys_rst;
    logic                 video_on;
    logic [SW-1:0]        x, y;
    logic                 frame_start;
    logic [CAMW-1:0]      camera_y;
    logic                 cfg_valid;
    logic [2:0]           cfg_layer;
    logic [PHW-1:0]       cfg_x, cfg_y;
    logic [SW-1:0]        cfg_w, cfg_h;
    logic                 cfg_en;
    logic                 cfg_ready;
    logic                 cfg_commit;
    logic [LN-1:0]        layer_on;
    logic [LN*SW-1:0]     layer_x_rom, layer_y_rom;
    logic [LN*PW-1:0]     layer_rgb;
    logic [PW-1:0]        bg_rgb;
    logic [PW-1:0]        rgb;
    logic                 video_on_d;
    logic                 commit_busy;

    always #5 sys_clk = ~sys_clk;

    layer_compositor #(
        .LAYER_NUM(LN), .PIXEL_WIDTH(PW), .SCREEN_WIDTH(SW),
        .PHY_WIDTH(PHW), .CAMERA_WIDTH(CAMW), .BLOCK_WIDTH(480)
    ) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .video_on(video_on), .x(x), .y(y),
        .frame_start(frame_start), .camera_y(camera_y),
        .cfg_valid(cfg_valid), .cfg_layer(cfg_layer), .cfg_x(cfg_x), .cfg_y(cfg_y),
        .cfg_w(cfg_w), .cfg_h(cfg_h), .cfg_en(cfg_en), .cfg_ready(cfg_ready),
        .cfg_commit(cfg_commit), .layer_on(layer_on), .layer_x_rom(layer_x_rom),
        .layer_y_rom(layer_y_rom), .layer_rgb(layer_rgb), .bg_rgb(bg_rgb), .rgb(rgb),
        .video_on_d(video_on_d), .commit_busy(commit_busy)
    );

    typedef struct {
        int          phase;
        logic [9:0]  vx, vy;
        logic        von;
        logic [11:0] l0;
        logic [7:0]  on;
        int          lay;
        logic [9:0]  xr, yr;
        logic [11:0] rgb;
        logic        vod;
    } vec_t;

    vec_t vt[$];
    int checks = 0;
    int errors = 0;

`ifdef LAYER_COLORKEY_EN
    localparam logic [PW-1:0] KEYED_EXP = 12'h440;
`else
    localparam logic [PW-1:0] KEYED_EXP = 12'hF0F;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input int ph, input int vx, input int vy, input logic von,
                       input logic [11:0] l0, input logic [7:0] on, input int lay,
                       input int xr, input int yr, input logic [11:0] er, input logic vod);
        vec_t v;
        v.phase = ph; v.vx = 10'(vx); v.vy = 10'(vy); v.von = von; v.l0 = l0;
        v.on = on; v.lay = lay; v.xr = 10'(xr); v.yr = 10'(yr); v.rgb = er; v.vod = vod;
        vt.push_back(v);
    endtask

    task automatic run_vec(input vec_t v);
        layer_rgb[PW-1:0] = v.l0;
        x = v.vx; y = v.vy; video_on = v.von;
        @(negedge sys_clk);
        check($sformatf("p%0d layer_on (%0d,%0d)", v.phase, v.vx, v.vy), 32'(layer_on), 32'(v.on));
        check($sformatf("p%0d x_rom%0d (%0d,%0d)", v.phase, v.lay, v.vx, v.vy),
              32'(layer_x_rom[v.lay*SW +: SW]), 32'(v.xr));
        check($sformatf("p%0d y_rom%0d (%0d,%0d)", v.phase, v.lay, v.vx, v.vy),
              32'(layer_y_rom[v.lay*SW +: SW]), 32'(v.yr));
        repeat (2) @(negedge sys_clk);
        check($sformatf("p%0d rgb (%0d,%0d)", v.phase, v.vx, v.vy), 32'(rgb), 32'(v.rgb));
        check($sformatf("p%0d video_on_d (%0d,%0d)", v.phase, v.vx, v.vy), 32'(video_on_d), 32'(v.vod));
    endtask

    task automatic run_phase(input int p);
        foreach (vt[i]) begin
            if (vt[i].phase == p) run_vec(vt[i]);
        end
    endtask

    task automatic cfg_set(input int l, input int ax, input int ay, input int w, input int h, input logic en);
        cfg_layer = 3'(l); cfg_x = 16'(ax); cfg_y = 16'(ay);
        cfg_w = 10'(w); cfg_h = 10'(h); cfg_en = en;
    endtask

    task automatic cfg_wr(input int l, input int ax, input int ay, input int w, input int h, input logic en);
        cfg_set(l, ax, ay, w, h, en);
        cfg_valid = 1'b1;
        @(negedge sys_clk);
        cfg_valid = 1'b0;
    endtask

    task automatic commit();
        cfg_commit = 1'b1;
        @(negedge sys_clk);
        cfg_commit = 1'b0;
    endtask

    task automatic fstart();
        frame_start = 1'b1;
        @(negedge sys_clk);
        frame_start = 1'b0;
    endtask

    logic [PW-1:0] ex_rgb [24];
    logic          ex_vod [24];

    initial begin
        // phase 1: layer0 at (100,50) 42x50, camera 0
        add(1, 100,  50, 1, 12'h110, 8'h01, 0,  0,  0, 12'h110, 1);
        add(1, 142,  50, 1, 12'h110, 8'h00, 0,  0,  0, BG,      1);
        add(1, 141,  99, 1, 12'h110, 8'h01, 0, 41, 49, 12'h110, 1);
        add(1, 141, 100, 1, 12'h110, 8'h00, 0,  0,  0, BG,      1);
        add(1,  99,  60, 1, 12'h110, 8'h00, 0,  0,  0, BG,      1);
        add(1, 120,  70, 0, 12'h110, 8'h01, 0, 20, 20, 12'h000, 0);
        // phase 2: layer3 written/committed but not yet swapped in
        add(2, 150,  60, 1, 12'h110, 8'h00, 3,  0,  0, BG,      1);
        // phase 3: layer3 (110,40) 100x100 active, overlaps layer0
        add(3, 150,  60, 1, 12'h110, 8'h08, 3, 40, 20, 12'h440, 1);
        add(3, 120,  60, 1, 12'h110, 8'h09, 0, 20, 10, 12'h110, 1);
        add(3, 120,  60, 1, 12'hF0F, 8'h09, 3, 10, 20, KEYED_EXP, 1);
        add(3, 110,  40, 1, 12'h110, 8'h08, 3,  0,  0, 12'h440, 1);
        add(3, 209, 139, 1, 12'h110, 8'h08, 3, 99, 99, 12'h440, 1);
        add(3, 210, 100, 1, 12'h110, 8'h00, 3,  0,  0, BG,      1);
        // phase 4: camera 1 (offset 480), layer1 at (0,500) 10x10
        add(4,   5,  20, 1, 12'h110, 8'h02, 1,  5,  0, 12'h220, 1);
        add(4,   5,  19, 1, 12'h110, 8'h00, 1,  0,  0, BG,      1);
        add(4,   9,  29, 1, 12'h110, 8'h02, 1,  9,  9, 12'h220, 1);
        add(4,   9,  30, 1, 12'h110, 8'h00, 1,  0,  0, BG,      1);
        add(4, 120,  60, 1, 12'h110, 8'h00, 0,  0,  0, BG,      1);
        // phase 5/6: layer7 (300,600) 8x8 before/after the delayed commit, camera 1
        add(5, 300, 120, 1, 12'h110, 8'h00, 7,  0,  0, BG,      1);
        add(6, 300, 120, 1, 12'h110, 8'h80, 7,  0,  0, 12'h880, 1);
        add(6, 307, 127, 1, 12'h110, 8'h80, 7,  7,  7, 12'h880, 1);
        // phase 8: camera 0, refused layer6 write absent, accepted layer2 write present
        add(8, 605, 305, 1, 12'h110, 8'h00, 6,  0,  0, BG,      1);
        add(8, 705, 405, 1, 12'h110, 8'h04, 2,  5,  5, 12'h330, 1);
        add(8, 300, 600, 1, 12'h110, 8'h80, 7,  0,  0, 12'h880, 1);
        // phase 10: after reset every layer is disabled
        add(10, 705, 405, 1, 12'h110, 8'h00, 2, 0,  0, BG,      1);
        add(10, 300, 600, 1, 12'h110, 8'h00, 7, 0,  0, BG,      1);

        sys_rst = 1'b1; video_on = 1'b0; x = '0; y = '0; frame_start = 1'b0;
        camera_y = '0; cfg_valid = 1'b0; cfg_commit = 1'b0; cfg_set(0, 0, 0, 0, 0, 1'b0);
        bg_rgb = BG;
        for (int i = 0; i < LN; i++) layer_rgb[i*PW +: PW] = 12'(12'h110 * (i + 1));

        repeat (3) @(negedge sys_clk);
        check("reset rgb", 32'(rgb), 32'h0);
        check("reset video_on_d", 32'(video_on_d), 32'h0);
        check("reset layer_on", 32'(layer_on), 32'h0);
        check("reset commit_busy", 32'(commit_busy), 32'h0);
        sys_rst = 1'b0;
        @(negedge sys_clk);
        check("cfg_ready after reset", 32'(cfg_ready), 32'h1);

        // Unconfigured frame streamed one pixel per cycle: bg or blank, exactly 3 cycles late
        for (int k = 0; k < 24; k++) begin
            if (k >= 3) begin
                check($sformatf("bg stream rgb k=%0d", k), 32'(rgb), 32'(ex_rgb[k-3]));
                check($sformatf("bg stream vod k=%0d", k), 32'(video_on_d), 32'(ex_vod[k-3]));
            end
            x = 10'(k); y = 10'd10; video_on = (k % 5) != 4;
            ex_rgb[k] = video_on ? BG : 12'h000;
            ex_vod[k] = video_on;
            @(negedge sys_clk);
        end

        cfg_wr(0, 100, 50, 42, 50, 1'b1);
        commit();
        check("busy after commit", 32'(commit_busy), 32'h1);
        fstart();
        check("busy after frame_start", 32'(commit_busy), 32'h0);
        run_phase(1);

        cfg_wr(3, 110, 40, 100, 100, 1'b1);
        run_phase(2);
        commit();
        check("busy mid-frame commit", 32'(commit_busy), 32'h1);
        run_phase(2);
        fstart();
        run_phase(3);

        cfg_wr(1, 0, 500, 10, 10, 1'b1);
        commit();
        camera_y = 6'd1;
        fstart();
        run_phase(4);

        cfg_wr(7, 300, 600, 8, 8, 1'b1);
        cfg_commit = 1'b1; frame_start = 1'b1;
        @(negedge sys_clk);
        cfg_commit = 1'b0; frame_start = 1'b0;
        check("busy commit with frame_start", 32'(commit_busy), 32'h1);
        run_phase(5);
        fstart();
        check("busy after delayed swap", 32'(commit_busy), 32'h0);
        run_phase(6);

        commit();
        camera_y = 6'd0;
        frame_start = 1'b1;
        cfg_set(6, 600, 300, 20, 20, 1'b1);
        cfg_valid = 1'b1;
        #1 check("cfg_ready on swap cycle", 32'(cfg_ready), 32'h0);
        @(negedge sys_clk);
        frame_start = 1'b0;
        cfg_set(2, 700, 400, 16, 16, 1'b1);
        #1 check("cfg_ready after swap", 32'(cfg_ready), 32'h1);
        @(negedge sys_clk);
        cfg_valid = 1'b0;
        check("busy after swap", 32'(commit_busy), 32'h0);
        commit();
        fstart();
        run_phase(8);

        commit();
        x = 10'd705; y = 10'd405; video_on = 1'b1;
        repeat (3) @(negedge sys_clk);
        check("rgb before reset", 32'(rgb), 32'h330);
        check("busy before reset", 32'(commit_busy), 32'h1);
        sys_rst = 1'b1;
        @(negedge sys_clk);
        check("mid-line reset busy", 32'(commit_busy), 32'h0);
        check("mid-line reset rgb", 32'(rgb), 32'h0);
        check("mid-line reset video_on_d", 32'(video_on_d), 32'h0);
        check("mid-line reset layer_on", 32'(layer_on), 32'h0);
        sys_rst = 1'b0;
        @(negedge sys_clk);
        check("cfg_ready after mid-line reset", 32'(cfg_ready), 32'h1);
        fstart();
        run_phase(10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
